// File: rtl/rob_commit_pkg.sv
// Shared types and sizes for the re-order buffer commit end.
package rob_commit_pkg;
  localparam int ROB_DEPTH = 16;
  localparam int IDX_W     = 4;
  localparam int PREG_W    = 6;
  localparam int XLEN      = 32;

  typedef struct packed {
    logic              v;
    logic              instr_type;
    logic [PREG_W-1:0] phy_reg;
    logic [PREG_W-1:0] old_pd;
    logic [XLEN-1:0]   result;
    logic              comp;
  } rob_row;

  // p0 is hard-wired and stores never own a destination register
  function automatic logic releases_preg(input logic instr_type, input logic [PREG_W-1:0] old_pd);
    return !instr_type && (old_pd != '0);
  endfunction
endpackage

// File: rtl/rob_retire_sel.sv
// Decides how many rows retire from the head this cycle (0..2).
module rob_retire_sel
  import rob_commit_pkg::*;
(
  input  logic [IDX_W-1:0]     head,
  input  logic [ROB_DEPTH-1:0] row_v,
  input  logic [ROB_DEPTH-1:0] row_comp,
  output logic [1:0]           n_ret,
  output logic [IDX_W-1:0]     idx_1,
  output logic [IDX_W-1:0]     idx_2
);
  logic ok_1;
  logic ok_2;

  assign idx_1 = head;
  assign idx_2 = head + IDX_W'(1);
  assign ok_1  = row_v[idx_1] && row_comp[idx_1];
  assign ok_2  = ok_1 && row_v[idx_2] && row_comp[idx_2];
  assign n_ret = ok_2 ? 2'd2 : (ok_1 ? 2'd1 : 2'd0);
endmodule

// File: rtl/rob_commit.sv
// Re-order buffer storage with in-order retire of up to two rows per cycle.
module rob_commit
  import rob_commit_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              alloc_valid_1,
  input  logic              alloc_valid_2,
  input  logic              alloc_type_1,
  input  logic              alloc_type_2,
  input  logic [PREG_W-1:0] alloc_pd_1,
  input  logic [PREG_W-1:0] alloc_pd_2,
  input  logic [PREG_W-1:0] alloc_old_pd_1,
  input  logic [PREG_W-1:0] alloc_old_pd_2,
  output logic              alloc_ready,
  output logic [IDX_W-1:0]  alloc_idx_1,
  output logic [IDX_W-1:0]  alloc_idx_2,
  input  logic              cmp_valid_1,
  input  logic              cmp_valid_2,
  input  logic              cmp_valid_3,
  input  logic [IDX_W-1:0]  cmp_idx_1,
  input  logic [IDX_W-1:0]  cmp_idx_2,
  input  logic [IDX_W-1:0]  cmp_idx_3,
  input  logic [XLEN-1:0]   cmp_result_1,
  input  logic [XLEN-1:0]   cmp_result_2,
  input  logic [XLEN-1:0]   cmp_result_3,
  output logic              ret_valid_1,
  output logic              ret_valid_2,
  output logic              ret_type_1,
  output logic              ret_type_2,
  output logic [PREG_W-1:0] ret_dest_1,
  output logic [PREG_W-1:0] ret_dest_2,
  output logic [XLEN-1:0]   ret_data_1,
  output logic [XLEN-1:0]   ret_data_2,
  output logic              free_valid_1,
  output logic              free_valid_2,
  output logic [PREG_W-1:0] free_preg_1,
  output logic [PREG_W-1:0] free_preg_2,
  output logic [IDX_W:0]    rob_count,
  output logic              rob_empty
);
  logic [IDX_W-1:0]     head_reg;
  logic [IDX_W-1:0]     tail_reg;
  logic [IDX_W:0]       count_reg;
  rob_row               rows [ROB_DEPTH];
  logic [ROB_DEPTH-1:0] row_v;
  logic [ROB_DEPTH-1:0] row_comp;
  logic [1:0]           n_ret;
  logic [1:0]           n_alloc;
  logic [IDX_W-1:0]     ret_idx_1;
  logic [IDX_W-1:0]     ret_idx_2;
  logic                 sel_1;
  logic                 sel_2;
  logic                 do_alloc_1;
  logic                 do_alloc_2;

  assign alloc_ready = (count_reg <= (IDX_W+1)'(ROB_DEPTH - 2));
  assign alloc_idx_1 = tail_reg;
  assign alloc_idx_2 = tail_reg + IDX_W'(alloc_valid_1);
  assign do_alloc_1  = alloc_valid_1 && alloc_ready;
  assign do_alloc_2  = alloc_valid_2 && alloc_ready;
  assign n_alloc     = {1'b0, do_alloc_1} + {1'b0, do_alloc_2};
  assign sel_1       = (n_ret != 2'd0);
  assign sel_2       = (n_ret == 2'd2);
  assign rob_count   = count_reg;
  assign rob_empty   = (count_reg == '0);

  rob_retire_sel u_sel (
    .head     (head_reg),
    .row_v    (row_v),
    .row_comp (row_comp),
    .n_ret    (n_ret),
    .idx_1    (ret_idx_1),
    .idx_2    (ret_idx_2)
  );

  // Priority per row: allocation, then retire clear, then the lowest completing port.
  for (genvar gi = 0; gi < ROB_DEPTH; gi++) begin : g_row
    rob_row row_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        row_reg <= '0;
      end else if (flush) begin
        row_reg <= '0;
      end else if (do_alloc_1 && alloc_idx_1 == IDX_W'(gi)) begin
        row_reg <= '{v: 1'b1, instr_type: alloc_type_1, phy_reg: alloc_pd_1,
                     old_pd: alloc_old_pd_1, result: '0, comp: 1'b0};
      end else if (do_alloc_2 && alloc_idx_2 == IDX_W'(gi)) begin
        row_reg <= '{v: 1'b1, instr_type: alloc_type_2, phy_reg: alloc_pd_2,
                     old_pd: alloc_old_pd_2, result: '0, comp: 1'b0};
      end else if ((sel_1 && ret_idx_1 == IDX_W'(gi)) || (sel_2 && ret_idx_2 == IDX_W'(gi))) begin
        row_reg <= '0;
      end else if (row_reg.v && cmp_valid_1 && cmp_idx_1 == IDX_W'(gi)) begin
        row_reg.comp   <= 1'b1;
        row_reg.result <= cmp_result_1;
      end else if (row_reg.v && cmp_valid_2 && cmp_idx_2 == IDX_W'(gi)) begin
        row_reg.comp   <= 1'b1;
        row_reg.result <= cmp_result_2;
      end else if (row_reg.v && cmp_valid_3 && cmp_idx_3 == IDX_W'(gi)) begin
        row_reg.comp   <= 1'b1;
        row_reg.result <= cmp_result_3;
      end
    end
    assign rows[gi]     = row_reg;
    assign row_v[gi]    = row_reg.v;
    assign row_comp[gi] = row_reg.comp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_reg + IDX_W'(n_ret);
      tail_reg  <= tail_reg + IDX_W'(n_alloc);
      count_reg <= count_reg + (IDX_W+1)'(n_alloc) - (IDX_W+1)'(n_ret);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ret_valid_1  <= 1'b0;
      ret_valid_2  <= 1'b0;
      ret_type_1   <= 1'b0;
      ret_type_2   <= 1'b0;
      ret_dest_1   <= '0;
      ret_dest_2   <= '0;
      ret_data_1   <= '0;
      ret_data_2   <= '0;
      free_valid_1 <= 1'b0;
      free_valid_2 <= 1'b0;
      free_preg_1  <= '0;
      free_preg_2  <= '0;
    end else if (flush) begin
      ret_valid_1  <= 1'b0;
      ret_valid_2  <= 1'b0;
      ret_type_1   <= 1'b0;
      ret_type_2   <= 1'b0;
      ret_dest_1   <= '0;
      ret_dest_2   <= '0;
      ret_data_1   <= '0;
      ret_data_2   <= '0;
      free_valid_1 <= 1'b0;
      free_valid_2 <= 1'b0;
      free_preg_1  <= '0;
      free_preg_2  <= '0;
    end else begin
      ret_valid_1  <= sel_1;
      ret_valid_2  <= sel_2;
      ret_type_1   <= sel_1 && rows[ret_idx_1].instr_type;
      ret_type_2   <= sel_2 && rows[ret_idx_2].instr_type;
      ret_dest_1   <= sel_1 ? rows[ret_idx_1].phy_reg : '0;
      ret_dest_2   <= sel_2 ? rows[ret_idx_2].phy_reg : '0;
      ret_data_1   <= sel_1 ? rows[ret_idx_1].result : '0;
      ret_data_2   <= sel_2 ? rows[ret_idx_2].result : '0;
      free_valid_1 <= sel_1 && releases_preg(rows[ret_idx_1].instr_type, rows[ret_idx_1].old_pd);
      free_valid_2 <= sel_2 && releases_preg(rows[ret_idx_2].instr_type, rows[ret_idx_2].old_pd);
      free_preg_1  <= sel_1 ? rows[ret_idx_1].old_pd : '0;
      free_preg_2  <= sel_2 ? rows[ret_idx_2].old_pd : '0;
    end
  end
endmodule

// File: tb/tb_rob_commit.sv
// Randomized and directed bench for rob_commit against a program-order queue model.
module tb_rob_commit;
  logic        clk = 1'b0;
  logic        rst_n, flush;
  logic        av1, av2, at1, at2;
  logic [5:0]  apd1, apd2, aold1, aold2;
  logic        alloc_ready;
  logic [3:0]  alloc_idx_1, alloc_idx_2;
  logic        cv1, cv2, cv3;
  logic [3:0]  ci1, ci2, ci3;
  logic [31:0] cr1, cr2, cr3;
  logic        ret_valid_1, ret_valid_2, ret_type_1, ret_type_2;
  logic [5:0]  ret_dest_1, ret_dest_2;
  logic [31:0] ret_data_1, ret_data_2;
  logic        free_valid_1, free_valid_2;
  logic [5:0]  free_preg_1, free_preg_2;
  logic [4:0]  rob_count;
  logic        rob_empty;

  rob_commit dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .alloc_valid_1(av1), .alloc_valid_2(av2), .alloc_type_1(at1), .alloc_type_2(at2),
    .alloc_pd_1(apd1), .alloc_pd_2(apd2), .alloc_old_pd_1(aold1), .alloc_old_pd_2(aold2),
    .alloc_ready(alloc_ready), .alloc_idx_1(alloc_idx_1), .alloc_idx_2(alloc_idx_2),
    .cmp_valid_1(cv1), .cmp_valid_2(cv2), .cmp_valid_3(cv3),
    .cmp_idx_1(ci1), .cmp_idx_2(ci2), .cmp_idx_3(ci3),
    .cmp_result_1(cr1), .cmp_result_2(cr2), .cmp_result_3(cr3),
    .ret_valid_1(ret_valid_1), .ret_valid_2(ret_valid_2),
    .ret_type_1(ret_type_1), .ret_type_2(ret_type_2),
    .ret_dest_1(ret_dest_1), .ret_dest_2(ret_dest_2),
    .ret_data_1(ret_data_1), .ret_data_2(ret_data_2),
    .free_valid_1(free_valid_1), .free_valid_2(free_valid_2),
    .free_preg_1(free_preg_1), .free_preg_2(free_preg_2),
    .rob_count(rob_count), .rob_empty(rob_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  idx;
    logic        typ;
    logic [5:0]  pd;
    logic [5:0]  old;
    logic        done;
    logic [31:0] res;
  } ent_t;

  ent_t q[$];
  int   alloc_cnt = 0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic idle_inputs();
    flush = 0; av1 = 0; av2 = 0; at1 = 0; at2 = 0;
    apd1 = 0; apd2 = 0; aold1 = 0; aold2 = 0;
    cv1 = 0; cv2 = 0; cv3 = 0; ci1 = 0; ci2 = 0; ci3 = 0;
    cr1 = 0; cr2 = 0; cr3 = 0;
  endtask

  task automatic apply_cmp(input logic v, input logic [3:0] idx, input logic [31:0] res);
    if (v) foreach (q[i]) if (q[i].idx == idx) begin q[i].done = 1'b1; q[i].res = res; end
  endtask

  // Position in q of the k-th entry that has not completed yet, or -1.
  function automatic int nth_pending(input int k);
    int seen = 0;
    foreach (q[i]) if (!q[i].done) begin
      if (seen == k) return i;
      seen++;
    end
    return -1;
  endfunction

  // One clock: check combinational outputs, advance the model, then check registered outputs.
  task automatic cycle();
    int   n;
    bit   rdy;
    ent_t r1, r2, e;
    #1;
    rdy = (q.size() <= 14);
    check_eq("alloc_ready", alloc_ready, rdy);
    check_eq("alloc_idx_1", alloc_idx_1, 64'(alloc_cnt % 16));
    check_eq("alloc_idx_2", alloc_idx_2, 64'((alloc_cnt + int'(av1)) % 16));
    n = 0;
    if (q.size() > 0 && q[0].done) begin n = 1; r1 = q[0]; end
    if (n == 1 && q.size() > 1 && q[1].done) begin n = 2; r2 = q[1]; end
    if (flush) begin
      q.delete(); alloc_cnt = 0; n = 0;
    end else begin
      apply_cmp(cv3, ci3, cr3);
      apply_cmp(cv2, ci2, cr2);
      apply_cmp(cv1, ci1, cr1);
      repeat (n) void'(q.pop_front());
      if (rdy && av1) begin
        e = '{idx: 4'(alloc_cnt % 16), typ: at1, pd: apd1, old: aold1, done: 1'b0, res: 32'h0};
        q.push_back(e); alloc_cnt++;
      end
      if (rdy && av2) begin
        e = '{idx: 4'(alloc_cnt % 16), typ: at2, pd: apd2, old: aold2, done: 1'b0, res: 32'h0};
        q.push_back(e); alloc_cnt++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    $display("cycle %0d: ret=%0d count=%0d", cyc, n, q.size());
    check_eq("ret_valid_1", ret_valid_1, n >= 1);
    check_eq("ret_valid_2", ret_valid_2, n == 2);
    check_eq("free_valid_1", free_valid_1, n >= 1 && !r1.typ && r1.old != 0);
    check_eq("free_valid_2", free_valid_2, n == 2 && !r2.typ && r2.old != 0);
    if (n >= 1) begin
      check_eq("ret_type_1", ret_type_1, r1.typ);
      check_eq("ret_dest_1", ret_dest_1, r1.pd);
      check_eq("ret_data_1", ret_data_1, r1.res);
      if (!r1.typ && r1.old != 0) check_eq("free_preg_1", free_preg_1, r1.old);
    end
    if (n == 2) begin
      check_eq("ret_type_2", ret_type_2, r2.typ);
      check_eq("ret_dest_2", ret_dest_2, r2.pd);
      check_eq("ret_data_2", ret_data_2, r2.res);
      if (!r2.typ && r2.old != 0) check_eq("free_preg_2", free_preg_2, r2.old);
    end
    check_eq("rob_count", rob_count, q.size());
    check_eq("rob_empty", rob_empty, q.size() == 0);
  endtask

  // Complete the two oldest pending rows each cycle until the ROB drains.
  task automatic drain();
    int p;
    for (int k = 0; k < 40 && q.size() != 0; k++) begin
      idle_inputs();
      p = nth_pending(0);
      if (p >= 0) begin cv1 = 1; ci1 = q[p].idx; cr1 = $urandom; end
      p = nth_pending(1);
      if (p >= 0) begin cv2 = 1; ci2 = q[p].idx; cr2 = $urandom; end
      cycle();
    end
    check_eq("drain_rows_left", 64'(q.size()), 0);
    idle_inputs();
  endtask

  task automatic pick_cmp(output logic v, output logic [3:0] idx, output logic [31:0] res);
    v = ($urandom_range(0, 9) < 6);
    if (q.size() > 0 && $urandom_range(0, 3) != 0) idx = q[$urandom_range(0, q.size() - 1)].idx;
    else idx = 4'($urandom_range(0, 15));
    res = $urandom;
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;

    // reset state and idle
    check_eq("reset_empty", rob_empty, 1);
    check_eq("reset_count", rob_count, 0);
    check_eq("reset_ret_valid_1", ret_valid_1, 0);
    cycle();

    // two register rows completed together retire together
    av1 = 1; apd1 = 33; aold1 = 5; av2 = 1; apd2 = 34; aold2 = 6;
    cycle();
    idle_inputs();
    cv1 = 1; ci1 = 0; cr1 = 32'h11; cv2 = 1; ci2 = 1; cr2 = 32'h22;
    cycle();
    idle_inputs();
    cycle();
    check_eq("pair_dest_1", ret_dest_1, 33);
    check_eq("pair_data_2", ret_data_2, 32'h22);
    check_eq("pair_free_2", free_preg_2, 6);

    // younger row completes first; both retire only once the older completes
    av1 = 1; apd1 = 20; aold1 = 7; av2 = 1; apd2 = 21; aold2 = 8;
    cycle();
    idle_inputs();
    cv1 = 1; ci1 = 3; cr1 = 32'hBB;
    cycle();
    idle_inputs();
    cycle();
    cv3 = 1; ci3 = 2; cr3 = 32'hAA;
    cycle();
    idle_inputs();
    cycle();
    check_eq("ooo_data_1", ret_data_1, 32'hAA);
    check_eq("ooo_data_2", ret_data_2, 32'hBB);

    // fill to capacity, then sustain 2 retire + 2 alloc across the wrap
    for (int k = 0; k < 8; k++) begin
      av1 = 1; av2 = 1; apd1 = 6'(k + 40); apd2 = 6'(k + 50); aold1 = 6'(k + 1); aold2 = 0;
      cycle();
    end
    idle_inputs();
    check_eq("full_count", rob_count, 16);
    check_eq("full_ready", alloc_ready, 0);
    for (int k = 0; k < 24; k++) begin
      int p;
      idle_inputs();
      p = nth_pending(0);
      if (p >= 0) begin cv1 = 1; ci1 = q[p].idx; cr1 = $urandom; end
      p = nth_pending(1);
      if (p >= 0) begin cv2 = 1; ci2 = q[p].idx; cr2 = $urandom; end
      if (q.size() <= 14) begin
        av1 = 1; av2 = 1; apd1 = 6'($urandom); apd2 = 6'($urandom);
        aold1 = 6'($urandom); aold2 = 6'($urandom);
      end
      cycle();
    end
    drain();

    // store row and a register row whose old mapping is p0
    av1 = 1; at1 = 1; apd1 = 12; aold1 = 33; av2 = 1; at2 = 0; apd2 = 40; aold2 = 0;
    cycle();
    idle_inputs();
    cv1 = 1; ci1 = q[0].idx; cr1 = 32'h5; cv2 = 1; ci2 = q[1].idx; cr2 = 32'h6;
    cycle();
    idle_inputs();
    cycle();
    check_eq("store_type_1", ret_type_1, 1);
    check_eq("store_dest_1", ret_dest_1, 12);
    check_eq("store_free_1", free_valid_1, 0);
    check_eq("p0_free_2", free_valid_2, 0);

    // flush with 5 in flight, head pair complete so a retire is pending
    for (int k = 0; k < 3; k++) begin
      av1 = 1; av2 = (k < 2); apd1 = 6'(k + 10); apd2 = 6'(k + 20); aold1 = 6'(k + 1); aold2 = 6'(k + 4);
      cycle();
    end
    idle_inputs();
    cv1 = 1; ci1 = q[0].idx; cr1 = 32'hC1; cv2 = 1; ci2 = q[1].idx; cr2 = 32'hC2;
    cycle();
    idle_inputs();
    flush = 1;
    cycle();
    idle_inputs();
    check_eq("flush_ret_valid", ret_valid_1, 0);
    check_eq("flush_count", rob_count, 0);
    #1 check_eq("flush_alloc_idx", alloc_idx_1, 0);

    // async reset while a retire is being presented
    for (int k = 0; k < 3; k++) begin
      av1 = 1; av2 = (k < 2); apd1 = 6'(k + 30); apd2 = 6'(k + 35); aold1 = 6'(k + 9); aold2 = 6'(k + 12);
      cycle();
    end
    idle_inputs();
    cv1 = 1; ci1 = q[0].idx; cr1 = 32'hD1;
    cycle();
    cycle();
    check_eq("pre_reset_ret", ret_valid_1, 1);
    rst_n = 0;
    #1;
    check_eq("areset_ret_valid", ret_valid_1, 0);
    check_eq("areset_count", rob_count, 0);
    check_eq("areset_empty", rob_empty, 1);
    q.delete(); alloc_cnt = 0;
    #2 rst_n = 1;
    @(negedge clk);
    cycle();

    // randomized traffic with occasional flush
    for (int k = 0; k < 400; k++) begin
      idle_inputs();
      if (q.size() <= 14) begin
        av1 = 1'($urandom); av2 = 1'($urandom);
        at1 = ($urandom_range(0, 3) == 0); at2 = ($urandom_range(0, 3) == 0);
        apd1 = 6'($urandom); apd2 = 6'($urandom);
        aold1 = ($urandom_range(0, 4) == 0) ? 6'd0 : 6'($urandom);
        aold2 = ($urandom_range(0, 4) == 0) ? 6'd0 : 6'($urandom);
      end
      pick_cmp(cv1, ci1, cr1);
      pick_cmp(cv2, ci2, cr2);
      pick_cmp(cv3, ci3, cr3);
      flush = ($urandom_range(0, 59) == 0);
      cycle();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
